// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use hazard detection.
// Each clock edge applies one action to the EX slot:
//   flush > hold > bubble > load.
// The bubble counter records how many load-use bubbles were inserted.
// It saturates at all-ones.
module id_ex_pipe (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rdData1,
    input  logic [31:0] i_rdData2,
    input  logic [31:0] i_imm,
    input  logic [4:0]  i_rdReg1,
    input  logic [4:0]  i_rdReg2,
    input  logic [12:0] i_ctrlEX,
    input  logic [2:0]  i_ctrlMEM,
    input  logic [6:0]  i_ctrlWB,
    input  logic        i_flush,
    input  logic        i_exStall,
    output logic        o_valid,
    output logic [31:0] o_pc,
    output logic [31:0] o_rdData1,
    output logic [31:0] o_rdData2,
    output logic [31:0] o_imm,
    output logic [4:0]  o_rdReg1,
    output logic [4:0]  o_rdReg2,
    output logic [12:0] o_ctrlEX,
    output logic [2:0]  o_ctrlMEM,
    output logic [6:0]  o_ctrlWB,
    output logic        o_stallID,
    output logic [15:0] o_bubbleCnt
);

    logic        valid_q,     valid_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] rdData1_q,   rdData1_d;
    logic [31:0] rdData2_q,   rdData2_d;
    logic [31:0] imm_q,       imm_d;
    logic [4:0]  rdReg1_q,    rdReg1_d;
    logic [4:0]  rdReg2_q,    rdReg2_d;
    logic [12:0] ctrlEX_q,    ctrlEX_d;
    logic [2:0]  ctrlMEM_q,   ctrlMEM_d;
    logic [6:0]  ctrlWB_q,    ctrlWB_d;
    logic [15:0] bubbleCnt_q, bubbleCnt_d;
    logic        hazard;

    // A load in EX whose destination (never x0) is read by the valid ID instruction.
    assign hazard = valid_q & ctrlMEM_q[1] & (ctrlWB_q[4:0] != 5'd0) & i_valid &
                    ((ctrlWB_q[4:0] == i_rdReg1) | (ctrlWB_q[4:0] == i_rdReg2));

    // The front end must hold while a bubble is due or EX is blocked.
    // A taken branch or a reset cancels that hold.
    assign o_stallID = (hazard | i_exStall) & ~i_flush & i_rst_n;

    // Select the single action for this edge and build the next EX slot.
    always_comb begin
        valid_d     = valid_q;
        pc_d        = pc_q;
        rdData1_d   = rdData1_q;
        rdData2_d   = rdData2_q;
        imm_d       = imm_q;
        rdReg1_d    = rdReg1_q;
        rdReg2_d    = rdReg2_q;
        ctrlEX_d    = ctrlEX_q;
        ctrlMEM_d   = ctrlMEM_q;
        ctrlWB_d    = ctrlWB_q;
        bubbleCnt_d = bubbleCnt_q;
        if (i_flush) begin
            pc_d      = i_pc;
            rdData1_d = i_rdData1;
            rdData2_d = i_rdData2;
            imm_d     = i_imm;
            rdReg1_d  = i_rdReg1;
            rdReg2_d  = i_rdReg2;
            ctrlEX_d  = i_ctrlEX;
            valid_d   = 1'b0;
            ctrlMEM_d = 3'b000;
            ctrlWB_d  = {2'b00, i_ctrlWB[4:0]};
        end else if (i_exStall) begin
            valid_d = valid_q;
        end else if (hazard) begin
            pc_d      = i_pc;
            rdData1_d = i_rdData1;
            rdData2_d = i_rdData2;
            imm_d     = i_imm;
            rdReg1_d  = i_rdReg1;
            rdReg2_d  = i_rdReg2;
            valid_d   = 1'b0;
            ctrlEX_d  = 13'd0;
            ctrlMEM_d = 3'b000;
            ctrlWB_d  = 7'd0;
            if (bubbleCnt_q != 16'hFFFF) begin
                bubbleCnt_d = bubbleCnt_q + 16'd1;
            end
        end else begin
            valid_d   = i_valid;
            pc_d      = i_pc;
            rdData1_d = i_rdData1;
            rdData2_d = i_rdData2;
            imm_d     = i_imm;
            rdReg1_d  = i_rdReg1;
            rdReg2_d  = i_rdReg2;
            ctrlEX_d  = i_ctrlEX;
            ctrlMEM_d = i_valid ? i_ctrlMEM : 3'b000;
            ctrlWB_d  = i_valid ? i_ctrlWB : {2'b00, i_ctrlWB[4:0]};
        end
    end

    // EX slot state, cleared asynchronously so a reset discards any in-flight instruction.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q     <= 1'b0;
            pc_q        <= 32'd0;
            rdData1_q   <= 32'd0;
            rdData2_q   <= 32'd0;
            imm_q       <= 32'd0;
            rdReg1_q    <= 5'd0;
            rdReg2_q    <= 5'd0;
            ctrlEX_q    <= 13'd0;
            ctrlMEM_q   <= 3'd0;
            ctrlWB_q    <= 7'd0;
            bubbleCnt_q <= 16'd0;
        end else begin
            valid_q     <= valid_d;
            pc_q        <= pc_d;
            rdData1_q   <= rdData1_d;
            rdData2_q   <= rdData2_d;
            imm_q       <= imm_d;
            rdReg1_q    <= rdReg1_d;
            rdReg2_q    <= rdReg2_d;
            ctrlEX_q    <= ctrlEX_d;
            ctrlMEM_q   <= ctrlMEM_d;
            ctrlWB_q    <= ctrlWB_d;
            bubbleCnt_q <= bubbleCnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_pc        = pc_q;
    assign o_rdData1   = rdData1_q;
    assign o_rdData2   = rdData2_q;
    assign o_imm       = imm_q;
    assign o_rdReg1    = rdReg1_q;
    assign o_rdReg2    = rdReg2_q;
    assign o_ctrlEX    = ctrlEX_q;
    assign o_ctrlMEM   = ctrlMEM_q;
    assign o_ctrlWB    = ctrlWB_q;
    assign o_bubbleCnt = bubbleCnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Self-checking bench for id_ex_pipe.
// The EX slot is tracked by a rule-level model that follows the action priority.
// The model tracks validity, control fields and the bubble count.
module tb_id_ex_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic [31:0] i_pc, i_rdData1, i_rdData2, i_imm;
    logic [4:0]  i_rdReg1, i_rdReg2;
    logic [12:0] i_ctrlEX;
    logic [2:0]  i_ctrlMEM;
    logic [6:0]  i_ctrlWB;
    logic        i_flush, i_exStall;
    logic        o_valid;
    logic [31:0] o_pc, o_rdData1, o_rdData2, o_imm;
    logic [4:0]  o_rdReg1, o_rdReg2;
    logic [12:0] o_ctrlEX;
    logic [2:0]  o_ctrlMEM;
    logic [6:0]  o_ctrlWB;
    logic        o_stallID;
    logic [15:0] o_bubbleCnt;

    int nChecks = 0;
    int nFails  = 0;

    // Expected EX slot contents.
    logic        m_valid, m_bubbled;
    logic [31:0] m_pc, m_rd1, m_rd2, m_imm;
    logic [4:0]  m_rs1, m_rs2;
    logic [12:0] m_ex;
    logic [2:0]  m_mem;
    logic [6:0]  m_wb;
    logic [15:0] m_cnt;

    id_ex_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_pc(i_pc),
        .i_rdData1(i_rdData1), .i_rdData2(i_rdData2), .i_imm(i_imm),
        .i_rdReg1(i_rdReg1), .i_rdReg2(i_rdReg2), .i_ctrlEX(i_ctrlEX),
        .i_ctrlMEM(i_ctrlMEM), .i_ctrlWB(i_ctrlWB), .i_flush(i_flush),
        .i_exStall(i_exStall), .o_valid(o_valid), .o_pc(o_pc),
        .o_rdData1(o_rdData1), .o_rdData2(o_rdData2), .o_imm(o_imm),
        .o_rdReg1(o_rdReg1), .o_rdReg2(o_rdReg2), .o_ctrlEX(o_ctrlEX),
        .o_ctrlMEM(o_ctrlMEM), .o_ctrlWB(o_ctrlWB), .o_stallID(o_stallID),
        .o_bubbleCnt(o_bubbleCnt)
    );

    always #5 i_clk = ~i_clk;

    function automatic logic modelHazard();
        return m_valid && m_mem[1] && (m_wb[4:0] != 5'd0) && i_valid &&
               ((m_wb[4:0] == i_rdReg1) || (m_wb[4:0] == i_rdReg2));
    endfunction

    function automatic logic modelStall();
        return (modelHazard() || i_exStall) && !i_flush && i_rst_n;
    endfunction

    task automatic modelReset();
        m_valid = 0; m_bubbled = 0; m_pc = 0; m_rd1 = 0; m_rd2 = 0; m_imm = 0;
        m_rs1 = 0; m_rs2 = 0; m_ex = 0; m_mem = 0; m_wb = 0; m_cnt = 0;
    endtask

    // One clock edge of the EX slot, following flush > hold > bubble > load.
    task automatic modelEdge();
        if (i_flush) begin
            m_valid = 0; m_mem = 0; m_wb = {2'b00, i_ctrlWB[4:0]}; m_bubbled = 0;
        end else if (i_exStall) begin
            m_valid = m_valid;
        end else if (modelHazard()) begin
            m_valid = 0; m_mem = 0; m_wb = 0; m_ex = 0; m_bubbled = 1;
            m_cnt = (m_cnt == 16'hFFFF) ? m_cnt : m_cnt + 16'd1;
        end else begin
            m_valid = i_valid; m_pc = i_pc; m_rd1 = i_rdData1; m_rd2 = i_rdData2;
            m_imm = i_imm; m_rs1 = i_rdReg1; m_rs2 = i_rdReg2; m_ex = i_ctrlEX;
            m_mem = i_valid ? i_ctrlMEM : 3'b000;
            m_wb = i_valid ? i_ctrlWB : {2'b00, i_ctrlWB[4:0]};
            m_bubbled = 0;
        end
    endtask

    task automatic stepEdge();
        @(posedge i_clk);
        modelEdge();
        #1;
    endtask

    task automatic driveId(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [12:0] ex, input logic [2:0] mem, input logic [6:0] wb);
        i_valid = v; i_rdReg1 = rs1; i_rdReg2 = rs2;
        i_ctrlEX = ex; i_ctrlMEM = mem; i_ctrlWB = wb;
        i_pc = $urandom; i_rdData1 = $urandom; i_rdData2 = $urandom; i_imm = $urandom;
    endtask

    task automatic test_reset();
        i_rst_n = 0; i_flush = 0; i_exStall = 1;
        driveId(1, 5'd3, 5'd4, 13'h1ABC, 3'b010, 7'h43);
        modelReset();
        repeat (2) @(posedge i_clk);
        #1;
        nChecks++;
        if ({o_valid, o_pc, o_rdData1, o_rdData2, o_imm} !== 97'd0) begin
            nFails++;
            $display("[TB] FAIL reset_data: got %h expected 0", {o_valid, o_pc, o_rdData1, o_rdData2, o_imm});
        end
        nChecks++;
        if ({o_rdReg1, o_rdReg2, o_ctrlEX, o_ctrlMEM, o_ctrlWB} !== 33'd0) begin
            nFails++;
            $display("[TB] FAIL reset_ctrl: got %h expected 0", {o_rdReg1, o_rdReg2, o_ctrlEX, o_ctrlMEM, o_ctrlWB});
        end
        nChecks++;
        if (o_bubbleCnt !== 16'd0) begin
            nFails++;
            $display("[TB] FAIL reset_cnt: got %h expected 0", o_bubbleCnt);
        end
        nChecks++;
        if (o_stallID !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL reset_stall: got %b expected 0", o_stallID);
        end
        @(negedge i_clk);
        i_rst_n = 1; i_exStall = 0;
        driveId(0, 5'd0, 5'd0, 13'd0, 3'b000, 7'd0);
    endtask

    task automatic test_load_use();
        logic [31:0] addPc;
        driveId(1, 5'd1, 5'd2, 13'h0400, 3'b010, 7'b1100101);
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1 || o_ctrlMEM !== 3'b010) begin
            nFails++;
            $display("[TB] FAIL lu_load: got valid=%b mem=%b expected 1 010", o_valid, o_ctrlMEM);
        end
        driveId(1, 5'd5, 5'd6, 13'h0A33, 3'b000, 7'b1000110);
        addPc = i_pc;
        #1;
        nChecks++;
        if (o_stallID !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL lu_stall: got %b expected 1", o_stallID);
        end
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b0 || o_ctrlWB !== 7'd0 || o_ctrlEX !== 13'd0 || o_ctrlMEM !== 3'd0) begin
            nFails++;
            $display("[TB] FAIL lu_bubble: got valid=%b wb=%h ex=%h mem=%b expected all 0",
                     o_valid, o_ctrlWB, o_ctrlEX, o_ctrlMEM);
        end
        nChecks++;
        if (o_bubbleCnt !== 16'd1) begin
            nFails++;
            $display("[TB] FAIL lu_cnt: got %h expected 0001", o_bubbleCnt);
        end
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1 || o_pc !== addPc || o_ctrlWB !== 7'b1000110) begin
            nFails++;
            $display("[TB] FAIL lu_reload: got valid=%b pc=%h wb=%h expected 1 %h 46", o_valid, o_pc, o_ctrlWB, addPc);
        end
    endtask

    task automatic test_x0();
        logic [15:0] cntBefore;
        driveId(1, 5'd1, 5'd2, 13'h0400, 3'b010, 7'b1100000);
        stepEdge();
        cntBefore = m_cnt;
        driveId(1, 5'd0, 5'd0, 13'h0000, 3'b000, 7'b1000011);
        #1;
        nChecks++;
        if (o_stallID !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL x0_stall: got %b expected 0", o_stallID);
        end
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1 || o_bubbleCnt !== cntBefore) begin
            nFails++;
            $display("[TB] FAIL x0_load: got valid=%b cnt=%h expected 1 %h", o_valid, o_bubbleCnt, cntBefore);
        end
    endtask

    task automatic test_flush();
        logic [15:0] cntBefore;
        driveId(1, 5'd1, 5'd2, 13'h0400, 3'b010, 7'b1101001);
        stepEdge();
        cntBefore = m_cnt;
        driveId(1, 5'd9, 5'd9, 13'h1FFF, 3'b111, 7'b1101010);
        i_flush = 1; i_exStall = 1;
        #1;
        nChecks++;
        if (o_stallID !== 1'b0) begin
            nFails++;
            $display("[TB] FAIL flush_stall: got %b expected 0", o_stallID);
        end
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b0 || o_ctrlMEM !== 3'b000 || o_ctrlWB[6:5] !== 2'b00 || o_bubbleCnt !== cntBefore) begin
            nFails++;
            $display("[TB] FAIL flush_slot: got valid=%b mem=%b wb65=%b cnt=%h expected 0 000 00 %h",
                     o_valid, o_ctrlMEM, o_ctrlWB[6:5], o_bubbleCnt, cntBefore);
        end
        i_flush = 0; i_exStall = 0;
    endtask

    task automatic test_ex_stall();
        logic [31:0] pcSnap, d1Snap;
        logic [6:0]  wbSnap;
        driveId(1, 5'd3, 5'd4, 13'h0455, 3'b001, 7'b0000000);
        stepEdge();
        pcSnap = i_pc; d1Snap = i_rdData1; wbSnap = 7'd0;
        i_exStall = 1;
        for (int k = 0; k < 3; k++) begin
            driveId(1, 5'(k + 10), 5'(k + 11), 13'($urandom), 3'b010, 7'($urandom));
            #1;
            nChecks++;
            if (o_stallID !== 1'b1) begin
                nFails++;
                $display("[TB] FAIL hold_stall%0d: got %b expected 1", k, o_stallID);
            end
            stepEdge();
            nChecks++;
            if (o_valid !== 1'b1 || o_pc !== pcSnap || o_rdData1 !== d1Snap ||
                o_ctrlMEM !== 3'b001 || o_ctrlWB !== wbSnap || o_ctrlEX !== 13'h0455) begin
                nFails++;
                $display("[TB] FAIL hold_keep%0d: got pc=%h d1=%h mem=%b expected %h %h 001",
                         k, o_pc, o_rdData1, o_ctrlMEM, pcSnap, d1Snap);
            end
        end
        i_exStall = 0;
        driveId(1, 5'd7, 5'd8, 13'h0123, 3'b000, 7'b1000111);
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1 || o_pc !== i_pc || o_rdData2 !== i_rdData2 || o_imm !== i_imm ||
            o_rdReg1 !== 5'd7 || o_rdReg2 !== 5'd8 || o_ctrlEX !== 13'h0123 || o_ctrlWB !== 7'b1000111) begin
            nFails++;
            $display("[TB] FAIL hold_release: got pc=%h rs=%0d/%0d ex=%h wb=%h expected %h 7/8 0123 47",
                     o_pc, o_rdReg1, o_rdReg2, o_ctrlEX, o_ctrlWB, i_pc);
        end
    endtask

    task automatic test_saturate();
        driveId(0, 5'd0, 5'd0, 13'd0, 3'b000, 7'd0);
        stepEdge();
        i_exStall = 1;
        force dut.bubbleCnt_d = 16'hFFFE;
        stepEdge();
        release dut.bubbleCnt_d;
        m_cnt = 16'hFFFE;
        i_exStall = 0;
        nChecks++;
        if (o_bubbleCnt !== 16'hFFFE) begin
            nFails++;
            $display("[TB] FAIL sat_preload: got %h expected FFFE", o_bubbleCnt);
        end
        driveId(1, 5'd7, 5'd7, 13'h0400, 3'b010, 7'b1100111);
        for (int k = 0; k < 6; k++) begin
            stepEdge();
            nChecks++;
            if (o_bubbleCnt !== m_cnt) begin
                nFails++;
                $display("[TB] FAIL sat_step%0d: got %h expected %h", k, o_bubbleCnt, m_cnt);
            end
        end
        nChecks++;
        if (o_bubbleCnt !== 16'hFFFF) begin
            nFails++;
            $display("[TB] FAIL sat_final: got %h expected FFFF", o_bubbleCnt);
        end
    endtask

    task automatic test_async_reset();
        driveId(1, 5'd1, 5'd2, 13'h0400, 3'b010, 7'b1100011);
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1) begin
            nFails++;
            $display("[TB] FAIL areset_pre: got %b expected 1", o_valid);
        end
        #2;
        i_rst_n = 0; i_exStall = 1;
        driveId(1, 5'd3, 5'd3, 13'h0, 3'b000, 7'd0);
        modelReset();
        #1;
        nChecks++;
        if ({o_valid, o_pc, o_ctrlMEM, o_ctrlWB, o_ctrlEX, o_bubbleCnt, o_stallID} !== 73'd0) begin
            nFails++;
            $display("[TB] FAIL areset_now: got valid=%b pc=%h mem=%b cnt=%h stall=%b expected all 0",
                     o_valid, o_pc, o_ctrlMEM, o_bubbleCnt, o_stallID);
        end
        @(negedge i_clk);
        i_rst_n = 1; i_exStall = 0;
        driveId(1, 5'd3, 5'd3, 13'h0999, 3'b000, 7'b1000100);
        stepEdge();
        nChecks++;
        if (o_valid !== 1'b1 || o_pc !== i_pc || o_ctrlWB !== 7'b1000100) begin
            nFails++;
            $display("[TB] FAIL areset_load: got valid=%b pc=%h wb=%h expected 1 %h 44", o_valid, o_pc, o_ctrlWB, i_pc);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            driveId(($urandom_range(3, 0) != 0), 5'($urandom_range(3, 0)), 5'($urandom_range(3, 0)),
                    13'($urandom), 3'($urandom), {2'($urandom), 5'($urandom_range(3, 0))});
            i_flush   = ($urandom_range(7, 0) == 0);
            i_exStall = ($urandom_range(5, 0) == 0);
            #1;
            nChecks++;
            if (o_stallID !== modelStall()) begin
                nFails++;
                $display("[TB] FAIL rnd_stall%0d: got %b expected %b", n, o_stallID, modelStall());
            end
            stepEdge();
            nChecks++;
            if (o_valid !== m_valid || o_ctrlMEM !== m_mem || o_ctrlWB[6:5] !== m_wb[6:5] || o_bubbleCnt !== m_cnt) begin
                nFails++;
                $display("[TB] FAIL rnd_slot%0d: got valid=%b mem=%b wb65=%b cnt=%h expected %b %b %b %h",
                         n, o_valid, o_ctrlMEM, o_ctrlWB[6:5], o_bubbleCnt, m_valid, m_mem, m_wb[6:5], m_cnt);
            end
            if (m_valid) begin
                nChecks++;
                if (o_pc !== m_pc || o_rdData1 !== m_rd1 || o_rdData2 !== m_rd2 || o_imm !== m_imm ||
                    o_rdReg1 !== m_rs1 || o_rdReg2 !== m_rs2 || o_ctrlEX !== m_ex || o_ctrlWB !== m_wb) begin
                    nFails++;
                    $display("[TB] FAIL rnd_data%0d: got pc=%h ex=%h wb=%h expected %h %h %h",
                             n, o_pc, o_ctrlEX, o_ctrlWB, m_pc, m_ex, m_wb);
                end
            end
            if (m_bubbled) begin
                nChecks++;
                if (o_ctrlEX !== 13'd0 || o_ctrlWB !== 7'd0) begin
                    nFails++;
                    $display("[TB] FAIL rnd_bubble%0d: got ex=%h wb=%h expected 0 0", n, o_ctrlEX, o_ctrlWB);
                end
            end
        end
        i_flush = 0; i_exStall = 0;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_x0();
        test_flush();
        test_ex_stall();
        test_saturate();
        test_async_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/id_ex_pipe.md
ID_EX_PIPE -- requirements
Module: id_ex_pipe

Interface
REQ-001 SHALL have port i_clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst_n, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have inputs i_valid 1, i_pc 32, i_rdData1 32, i_rdData2 32, i_imm 32: ID-stage instruction valid, PC, register-file read data, sign-extended immediate.
REQ-004 SHALL have inputs i_rdReg1 5, i_rdReg2 5, i_ctrlEX 13, i_ctrlMEM 3, i_ctrlWB 7: ID decode outputs. Layouts: ctrlEX = ALUop[12:11], ALUSrc[10], func3[9:7], func7[6:0]; ctrlMEM = Branch[2], MemRead[1], MemWrite[0]; ctrlWB = RegWrite[6], MemtoReg[5], rd[4:0].
REQ-005 SHALL have inputs i_flush 1 (branch taken, kill ID instruction) and i_exStall 1 (EX/MEM cannot accept).
REQ-006 SHALL have registered outputs o_valid 1, o_pc 32, o_rdData1 32, o_rdData2 32, o_imm 32, o_rdReg1 5, o_rdReg2 5, o_ctrlEX 13, o_ctrlMEM 3, o_ctrlWB 7: EX-stage copies of the inputs.
REQ-007 SHALL have output o_stallID 1 (combinational): PC and IF/ID must hold this cycle.
REQ-008 SHALL have output o_bubbleCnt 16: saturating count of load-use bubbles inserted.

Function
REQ-009 Hazard SHALL be defined as o_valid & o_ctrlMEM[1] & (o_ctrlWB[4:0] != 0) & i_valid & ((o_ctrlWB[4:0] == i_rdReg1) | (o_ctrlWB[4:0] == i_rdReg2)).
REQ-010 o_stallID SHALL equal (hazard | i_exStall) & ~i_flush.
REQ-011 Each edge SHALL apply exactly one action, priority order: flush > hold > bubble > load.
REQ-012 Flush (i_flush=1): o_valid <= 0, o_ctrlMEM <= 0, o_ctrlWB[6:5] <= 0; other fields don't-care; overrides i_exStall and hazard.
REQ-013 Hold (i_exStall=1, no flush): all outputs keep their values.
REQ-014 Bubble (hazard, no flush, no exStall): o_valid <= 0, o_ctrlMEM <= 0, o_ctrlWB <= 0, o_ctrlEX <= 0; o_bubbleCnt increments, saturating at 16'hFFFF.
REQ-015 Load (otherwise): all outputs <= corresponding inputs; o_valid <= i_valid. An invalid input SHALL be loaded with ctrlMEM and ctrlWB[6:5] forced to 0.
REQ-016 Latency SHALL be one cycle from ID inputs to outputs; a hazard SHALL insert exactly one bubble per load-use pair.
REQ-017 A valid output SHALL never carry a nonzero MemWrite, MemRead or RegWrite from a flushed or bubbled slot.
REQ-018 rd = x0 SHALL never cause a hazard; a hazard on both sources SHALL still insert a single bubble.

Reset
REQ-019 While i_rst_n=0, all registered outputs SHALL be 0, including o_valid and o_bubbleCnt, regardless of clock.
REQ-020 Reset mid-stall or mid-bubble SHALL discard the in-flight instruction; the first edge after release performs a normal load.
REQ-021 o_stallID SHALL be 0 during reset.

Verification
REQ-022 Load x5 (ctrlMEM=010, rd=5) in EX; ID add rs1=5, valid -> o_stallID=1; next edge o_valid=0, ctrlWB=0, o_bubbleCnt=1; following edge add loads, o_valid=1.
REQ-023 Load rd=0 in EX; ID rs1=0 -> o_stallID=0, no bubble, o_bubbleCnt unchanged.
REQ-024 Hazard present with i_flush=1 -> o_stallID=0; next edge o_valid=0, o_ctrlMEM=000, o_bubbleCnt unchanged.
REQ-025 Valid store in EX, i_exStall=1 for 3 cycles while ID inputs change -> outputs constant, o_stallID=1 each cycle; released edge loads new ID values.
REQ-026 Preload o_bubbleCnt=16'hFFFE, force 3 hazards -> reads 16'hFFFF, stays there.
REQ-027 Assert i_rst_n=0 asynchronously between edges while o_valid=1 -> outputs 0 immediately; release -> normal load next edge.
